digit_scan_ctrl: RTL and testbench
==================================

# digit_scan_ctrl

Time-multiplexed display controller for the counter exercise. Holds an NDIGITS-wide packed BCD/hex value and shares one external `bin_to_hex` decoder across all digits. Each digit slot presents one nibble to the decoder, registers the returned segment pattern, and enables that digit's anode. The block sits between the counter datapath and the board's 7-segment pins.

## Interface
Parameters:
- `NDIGITS`, 4: number of digits scanned (≥2).
- `PRESCALE`, 1000: clock cycles per digit slot (≥2).

Ports:
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `load` in 1: one-cycle strobe; requests capture of `value`.
- `value` in 4*NDIGITS: packed nibbles, digit 0 in bits [3:0].
- `dec_in` out 4: nibble driven to the shared `bin_to_hex` NUMBER input.
- `dec_out` in 8: segment pattern returned combinationally from `bin_to_hex` DIGITS.
- `seg` out 8: registered segment pattern to the pins (active-high).
- `an` out NDIGITS: digit enables, active-low, one-hot-low while showing.
- `frame_done` out 1: one-cycle pulse at the end of the last digit slot.

## Operation
- Internal state: `shadow` (4*NDIGITS), `pend_val` (4*NDIGITS), `pending` (1), digit index `idx` (0..NDIGITS-1), slot counter `cnt` (0..PRESCALE-1), FSM state {BLANK, SHOW}.
- Reset values: `seg`=0, `an`=all ones, `dec_in`=0, `frame_done`=0, `shadow`=0, `pending`=0, `idx`=0, `cnt`=0, state BLANK.
- BLANK (1 cycle): `an`=all ones (anti-ghosting). `dec_in`=shadow[idx]. At the clock edge, `seg` <= `dec_out` and `an` <= ~(1<<idx). Go to SHOW with `cnt`=1.
- SHOW (PRESCALE-1 cycles): hold `seg`/`an`; `cnt` increments. At `cnt`==PRESCALE-1, go to BLANK and set `idx`=idx+1, wrapping from NDIGITS-1 to 0.
- Frame boundary: the edge leaving SHOW with `idx`==NDIGITS-1. At that edge `frame_done` is set for exactly one cycle, and `shadow` <= `pend_val` if `pending`; `pending` is cleared.
- `load`: `pend_val` <= `value`, `pending` <= 1. A later `load` before the boundary overwrites `pend_val` (last wins). If `load` coincides with the boundary edge, `value` goes straight into `shadow` and `pending` stays 0.
- The displayed value never changes mid-frame (no tearing).
- Nibbles >9 pass unchanged to the decoder.
- `dec_in` is driven from `shadow[idx]` in every state.

## Timing
- Slot length is exactly PRESCALE cycles: 1 BLANK plus PRESCALE-1 SHOW. Frame length is NDIGITS*PRESCALE cycles.
- Decoder path is combinational `dec_in` -> `dec_out`, registered once into `seg`. Segment latency from slot start is 1 cycle.
- The first frame after reset starts with BLANK for digit 0 on the first active edge after `rst_n` rises.
- `load` to visible change: the first slot after the next frame boundary, at most NDIGITS*PRESCALE+1 cycles.
- `rst_n` low mid-frame: all outputs and state go immediately to their reset values; `pending` data is lost.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined: a digit k>0 whose nibble and all higher nibbles in `shadow` are 0 keeps `an`[k]=1 during its SHOW. Digit 0 is always shown. The check is evaluated at the BLANK edge of each slot.
- Not defined: all digits are shown, including leading zeros. Timing is identical either way.

## Test plan
- Reset: `rst_n`=0 mid-slot -> `an`=4'b1111, `seg`=0, `frame_done`=0 immediately; the first BLANK follows release.
- NDIGITS=4, PRESCALE=4, load 16'h1234: `dec_in` sequence 4,3,2,1 per frame; `an` shows 1110, 1101, 1011, 0111, each for 3 cycles after a 1-cycle 1111; `frame_done` every 16 cycles.
- `load` 16'h5678 in slot 1, then `load` 16'h9ABC in slot 2: the current frame keeps the old value; the next frame shows 16'h9ABC only; nibble A returns the decoder's hex pattern.
- `load` on the boundary edge: the next frame's digit 0 already shows the new value; `pending` reads 0.
- `LEADING_ZERO_BLANK_EN` with value 16'h0050: `an`[3] and `an`[2] stay 1 in their slots; digits 1 (5) and 0 (0) are shown. Value 16'h0000 shows only digit 0.
- Wrap: run 3 frames. `idx` goes 3 -> 0 with no extra cycle, and frame length is exactly 16 cycles.

Source files
------------

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller sharing one external nibble decoder.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses anodes of leading-zero digits.
module digit_scan_ctrl #(
    parameter int NDIGITS  = 4,
    parameter int PRESCALE = 1000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [4*NDIGITS-1:0]   value,
    output logic [3:0]             dec_in,
    input  logic [7:0]             dec_out,
    output logic [7:0]             seg,
    output logic [NDIGITS-1:0]     an,
    output logic                   frame_done
);

    // state | meaning
    // BLANK | all anodes off for one cycle; decoder result captured at its edge
    // SHOW  | one digit lit for PRESCALE-1 cycles
    typedef enum logic {BLANK, SHOW} state_t;

    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int CW = $clog2(PRESCALE);

    state_t                 state;
    logic [4*NDIGITS-1:0]   shadow;
    logic [4*NDIGITS-1:0]   pend_val;
    logic                   pending;
    logic [IW-1:0]          idx;
    logic [CW-1:0]          cnt;
    logic                   last_slot;
    logic                   last_digit;
    logic                   boundary;
    logic                   hi_zero;

    assign dec_in     = shadow[4*idx +: 4];
    assign last_slot  = (cnt == CW'(PRESCALE-1));
    assign last_digit = (idx == IW'(NDIGITS-1));
    assign boundary   = (state == SHOW) && last_slot && last_digit;

`ifdef LEADING_ZERO_BLANK_EN
    // Digit is a leading zero when it and every higher nibble are zero; digit 0 always lit.
    assign hi_zero = (idx != '0) && ((shadow >> (4*idx)) == '0);
`else
    assign hi_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BLANK;
            seg        <= '0;
            an         <= '1;
            frame_done <= 1'b0;
            shadow     <= '0;
            pend_val   <= '0;
            pending    <= 1'b0;
            idx        <= '0;
            cnt        <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                BLANK: begin
                    seg   <= dec_out;
                    an    <= hi_zero ? '1 : ~(NDIGITS'(1) << idx);
                    cnt   <= CW'(1);
                    state <= SHOW;
                end
                SHOW: begin
                    if (last_slot) begin
                        an    <= '1;
                        cnt   <= '0;
                        state <= BLANK;
                        idx   <= last_digit ? '0 : idx + IW'(1);
                        if (last_digit)
                            frame_done <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= BLANK;
            endcase

            // Shadow only moves on the frame boundary so a frame never tears.
            if (boundary) begin
                if (load)
                    shadow <= value;
                else if (pending)
                    shadow <= pend_val;
                pending <= 1'b0;
            end else if (load) begin
                pend_val <= value;
                pending  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Self-checking bench for digit_scan_ctrl against a cycle-index reference model.
module tb_digit_scan_ctrl;

    localparam int N  = 4;
    localparam int P  = 4;
    localparam int FR = N * P;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load;
    logic [15:0]   value;
    logic [3:0]    dec_in;
    logic [7:0]    dec_out;
    logic [7:0]    seg;
    logic [N-1:0]  an;
    logic          frame_done;

    int n_tests = 0;
    int n_fail  = 0;
    int c;
    logic [15:0] m_shadow;
    logic [15:0] m_pend_val;
    bit          m_pending;

    digit_scan_ctrl #(.NDIGITS(N), .PRESCALE(P)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value),
        .dec_in(dec_in), .dec_out(dec_out), .seg(seg), .an(an),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: seg_of = 8'h3F; 4'h1: seg_of = 8'h06; 4'h2: seg_of = 8'h5B; 4'h3: seg_of = 8'h4F;
            4'h4: seg_of = 8'h66; 4'h5: seg_of = 8'h6D; 4'h6: seg_of = 8'h7D; 4'h7: seg_of = 8'h07;
            4'h8: seg_of = 8'h7F; 4'h9: seg_of = 8'h6F; 4'hA: seg_of = 8'h77; 4'hB: seg_of = 8'h7C;
            4'hC: seg_of = 8'h39; 4'hD: seg_of = 8'h5E; 4'hE: seg_of = 8'h79; default: seg_of = 8'h71;
        endcase
    endfunction

    assign dec_out = seg_of(dec_in);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, c, got, exp);
        end
    endtask

    function automatic bit lz_hidden(input int dig);
`ifdef LEADING_ZERO_BLANK_EN
        return (dig > 0) && ((m_shadow >> (4*dig)) == 16'h0);
`else
        return 1'b0;
`endif
    endfunction

    // One cycle: check outputs mid-cycle, then drive load for the closing edge.
    task automatic do_cycle(input bit ld, input logic [15:0] v);
        int pos, dig;
        logic [3:0] nib;
        logic [N-1:0] exp_an;
        @(negedge clk);
        pos = c % P;
        dig = (c / P) % N;
        nib = 4'((m_shadow >> (4*dig)) & 16'hF);
        if (pos == 0 || lz_hidden(dig)) exp_an = '1;
        else                            exp_an = ~(N'(1) << dig);
        check("an", 32'(an), 32'(exp_an));
        check("dec_in", 32'(dec_in), 32'(nib));
        if (pos != 0) check("seg", 32'(seg), 32'(seg_of(nib)));
        check("frame_done", 32'(frame_done), 32'((c > 0) && (c % FR == 0)));
        load  = ld;
        value = v;
        if (c % FR == FR - 1) begin
            if (ld)             m_shadow = v;
            else if (m_pending) m_shadow = m_pend_val;
            m_pending = 1'b0;
        end else if (ld) begin
            m_pend_val = v;
            m_pending  = 1'b1;
        end
        @(posedge clk);
        c++;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        c = 0;
        m_shadow = 16'h0; m_pend_val = 16'h0; m_pending = 1'b0;
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(5))
            0: pick = 16'h1234;
            1: pick = 16'h0050;
            2: pick = 16'h0000;
            3: pick = 16'h9ABC;
            4: pick = 16'h000F;
            default: pick = 16'($urandom);
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; load = 1'b0; value = 16'h0;
        c = 0;
        m_shadow = 16'h0; m_pend_val = 16'h0; m_pending = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'h0);
        check("rst_frame_done", 32'(frame_done), 32'h0);
        release_reset();

        // 0x1234 loaded in the first frame, shown from the second frame on.
        do_cycle(1'b1, 16'h1234);
        repeat (3*FR - 1) do_cycle(1'b0, 16'h0);

        // Two loads inside one frame: the last one wins at the next boundary.
        repeat (P + 1) do_cycle(1'b0, 16'h0);
        do_cycle(1'b1, 16'h5678);
        repeat (P - 1) do_cycle(1'b0, 16'h0);
        do_cycle(1'b1, 16'h9ABC);
        while (c % FR != 0) do_cycle(1'b0, 16'h0);
        repeat (2*FR) do_cycle(1'b0, 16'h0);

        // Load exactly on the boundary edge goes straight to the display.
        repeat (FR - 1) do_cycle(1'b0, 16'h0);
        do_cycle(1'b1, 16'h0050);
        check("pending_after_boundary_load", 32'(dut.pending), 32'(m_pending));
        repeat (FR - 1) do_cycle(1'b0, 16'h0);
        do_cycle(1'b1, 16'h0000);
        repeat (2*FR) do_cycle(1'b0, 16'h0);

        // Random loads, with extra weight on boundary cycles.
        for (int i = 0; i < 40*FR; i++) begin
            bit ld;
            ld = ($urandom_range(99) < 8) || ((c % FR == FR - 1) && ($urandom_range(3) == 0));
            do_cycle(ld, pick());
        end

        // Mid-slot reset drops pending data and restarts from BLANK of digit 0.
        while (c % P != 2) do_cycle(1'b0, 16'h0);
        do_cycle(1'b1, 16'hBEEF);
        @(negedge clk);
        rst_n = 1'b0;
        load  = 1'b0;
        #1;
        check("midrst_an", 32'(an), 32'hF);
        check("midrst_seg", 32'(seg), 32'h0);
        check("midrst_frame_done", 32'(frame_done), 32'h0);
        check("midrst_dec_in", 32'(dec_in), 32'h0);
        release_reset();
        repeat (3*FR) do_cycle(1'b0, 16'h0);
        do_cycle(1'b1, 16'h0A0C);
        repeat (3*FR) do_cycle(1'b0, 16'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
